// File: rtl/full_subtractor_fs_cell.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Purely combinational; chained by the top level into a ripple-borrow subtractor.
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   always_comb begin
      d    = a ^ b ^ bin;
      // Borrow when b exceeds a, or when they are equal and a borrow arrives.
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: {Bout,Diff} = A - Bin - C, one cycle of latency.
// Diff/Bout load only on in_valid and otherwise hold; out_valid tracks in_valid.
module full_subtractor #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] Bin,
   input  logic             C,
   input  logic             in_valid,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             out_valid
);

   logic [WIDTH:0]   borrow;
   logic [WIDTH-1:0] diff_c;

   assign borrow[0] = C;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fs_cell u_cell (
         .a    (A[i]),
         .b    (Bin[i]),
         .bin  (borrow[i]),
         .d    (diff_c[i]),
         .bout (borrow[i+1])
      );
   end

   logic [WIDTH-1:0] diff_d, diff_q;
   logic             bout_d, bout_q;
   logic             valid_d, valid_q;

   always_comb begin
      diff_d  = diff_q;
      bout_d  = bout_q;
      valid_d = in_valid;
      if (in_valid) begin
         diff_d = diff_c;
         bout_d = borrow[WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         diff_q  <= '0;
         bout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         valid_q <= valid_d;
      end
   end

   assign Diff      = diff_q;
   assign Bout      = bout_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor at WIDTH=1 and WIDTH=8 against an arithmetic model.
module tb_full_subtractor;

   logic clk = 1'b0;
   logic rst;

   logic       a1, b1, c1, v1;
   logic       d1, bo1, ov1;
   logic [7:0] a8, b8;
   logic       c8, v8;
   logic [7:0] d8;
   logic       bo8, ov8;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic       m1_diff, m1_bout, m1_v;
   logic [7:0] m8_diff;
   logic       m8_bout, m8_v;

   always #5 clk = ~clk;

   full_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .A(a1), .Bin(b1), .C(c1), .in_valid(v1),
      .Diff(d1), .Bout(bo1), .out_valid(ov1)
   );

   full_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .A(a8), .Bin(b8), .C(c8), .in_valid(v8),
      .Diff(d8), .Bout(bo8), .out_valid(ov8)
   );

   function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
      int r;
      r = int'(a) - int'(b) - int'(c);
      return r[1:0];
   endfunction

   function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int r;
      r = int'(a) - int'(b) - int'(c);
      return r[8:0];
   endfunction

   task automatic drive1(input logic a, input logic b, input logic c, input logic v);
      a1 = a; b1 = b; c1 = c; v1 = v;
   endtask

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
      a8 = a; b8 = b; c8 = c; v8 = v;
   endtask

   // Advance one rising edge, update the model from what the DUTs sampled, settle.
   task automatic step();
      logic [1:0] r1;
      logic [8:0] r8;
      @(posedge clk);
      if (rst) begin
         m1_diff = 0; m1_bout = 0; m1_v = 0;
         m8_diff = 0; m8_bout = 0; m8_v = 0;
      end else begin
         m1_v = v1;
         if (v1) begin
            r1 = ref1(a1, b1, c1);
            m1_bout = r1[1]; m1_diff = r1[0];
         end
         m8_v = v8;
         if (v8) begin
            r8 = ref8(a8, b8, c8);
            m8_bout = r8[8]; m8_diff = r8[7:0];
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive1(1'bx, 1'bx, 1'bx, 1'b0);
      drive8('x, 'x, 1'bx, 1'b0);
      #2;
      tests++;
      if ({d1, bo1, ov1} !== 3'b000) begin
         fails++; $display("FAIL reset_w1: got %b%b%b, want 000", d1, bo1, ov1);
      end
      tests++;
      if ({d8, bo8, ov8} !== 10'h0) begin
         fails++; $display("FAIL reset_w8: got %h/%b/%b, want 00/0/0", d8, bo8, ov8);
      end
      step();
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic test_exhaustive_w1();
      logic [1:0] tbl [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         @(negedge clk);
         drive1(v[2], v[1], v[0], 1'b1);
         drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
         step();
         tests++;
         if ({d1, bo1, ov1} !== {tbl[i], 1'b1}) begin
            fails++; $display("FAIL exhaustive_w1[%0d]: got D=%b B=%b V=%b, want D=%b B=%b V=1",
                              i, d1, bo1, ov1, tbl[i][1], tbl[i][0]);
         end
      end
   endtask

   task automatic test_latency();
      @(negedge clk);
      drive1(1'b0, 1'b0, 1'b1, 1'b1);     // Diff=1, Bout=1
      step();
      @(negedge clk);
      drive1(1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      tests++;
      if ({d1, bo1} !== 2'b11) begin
         fails++; $display("FAIL latency_before: got D=%b B=%b, want D=1 B=1", d1, bo1);
      end
      step();
      tests++;
      if ({d1, bo1, ov1} !== 3'b101) begin
         fails++; $display("FAIL latency_after: got D=%b B=%b V=%b, want D=1 B=0 V=1", d1, bo1, ov1);
      end
   endtask

   task automatic test_w8_values();
      logic [7:0] av [3] = '{8'h00, 8'h80, 8'h55};
      logic [7:0] bv [3] = '{8'h01, 8'h01, 8'h55};
      logic       cv [3] = '{1'b0, 1'b1, 1'b1};
      logic [8:0] ev [3] = '{9'h1FF, 9'h07E, 9'h1FF};
      drive1(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive8(av[i], bv[i], cv[i], 1'b1);
         step();
         tests++;
         if ({bo8, d8} !== ev[i] || ov8 !== 1'b1) begin
            fails++; $display("FAIL w8_fixed[%0d]: got B=%b D=%h V=%b, want B=%b D=%h V=1",
                              i, bo8, d8, ov8, ev[i][8], ev[i][7:0]);
         end
         @(negedge clk);
         drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
         step();
         tests++;
         if ({bo8, d8, ov8} !== {m8_bout, m8_diff, 1'b1}) begin
            fails++; $display("FAIL w8_random[%0d]: got B=%b D=%h V=%b, want B=%b D=%h V=1",
                              i, bo8, d8, ov8, m8_bout, m8_diff);
         end
      end
      // boundaries: maximum borrow, A=Bin with and without borrow-in
      for (int i = 0; i < 3; i++) begin
         logic [7:0] r;
         r = 8'($urandom);
         @(negedge clk);
         case (i)
            0: drive8(8'h00, 8'hFF, 1'b1, 1'b1);
            1: drive8(r, r, 1'b0, 1'b1);
            default: drive8(r, r, 1'b1, 1'b1);
         endcase
         step();
         tests++;
         if ({bo8, d8} !== ((i == 1) ? 9'h000 : ((i == 0) ? 9'h100 : 9'h1FF))) begin
            fails++; $display("FAIL w8_boundary[%0d]: got B=%b D=%h", i, bo8, d8);
         end
      end
   endtask

   task automatic test_hold();
      logic [7:0] hd8;
      logic       hb8, hd1, hb1;
      @(negedge clk);
      drive1(1'b1, 1'b1, 1'b1, 1'b1);
      drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      step();
      hd1 = m1_diff; hb1 = m1_bout; hd8 = m8_diff; hb8 = m8_bout;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive1(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
         step();
         tests++;
         if ({d1, bo1, ov1} !== {hd1, hb1, 1'b0} || {d8, bo8, ov8} !== {hd8, hb8, 1'b0}) begin
            fails++; $display("FAIL hold[%0d]: got w1 %b%b%b w8 %h/%b/%b, want w1 %b%b0 w8 %h/%b/0",
                              i, d1, bo1, ov1, d8, bo8, ov8, hd1, hb1, hd8, hb8);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      drive1(1'b0, 1'b0, 1'b1, 1'b1);
      drive8(8'h00, 8'hFF, 1'b1, 1'b1);
      step();
      tests++;
      if ({d1, bo1} !== 2'b11) begin
         fails++; $display("FAIL areset_pre: got D=%b B=%b, want D=1 B=1", d1, bo1);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({d1, bo1, ov1} !== 3'b000 || {d8, bo8, ov8} !== 10'h0) begin
         fails++; $display("FAIL areset_immediate: got w1 %b%b%b w8 %h/%b/%b, want all 0",
                           d1, bo1, ov1, d8, bo8, ov8);
      end
      step();
      tests++;
      if ({d1, bo1, ov1} !== 3'b000) begin
         fails++; $display("FAIL areset_held: got %b%b%b, want 000", d1, bo1, ov1);
      end
      @(negedge clk);
      rst = 1'b0;
      drive1(1'b1, 1'b0, 1'b0, 1'b1);
      step();
      tests++;
      if ({d1, bo1, ov1} !== 3'b101 || {bo8, d8} !== 9'h100) begin
         fails++; $display("FAIL areset_recover: got w1 %b%b%b w8 %b/%h, want w1 101 w8 1/00",
                           d1, bo1, ov1, bo8, d8);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         @(negedge clk);
         drive1(v[2], v[1], v[0], 1'b1);
         drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
         step();
         tests++;
         if ({d1, bo1, ov1} !== {m1_diff, m1_bout, 1'b1} ||
             {d8, bo8, ov8} !== {m8_diff, m8_bout, 1'b1}) begin
            fails++; $display("FAIL back_to_back[%0d]: got w1 %b%b%b w8 %h/%b/%b, want w1 %b%b1 w8 %h/%b/1",
                              i, d1, bo1, ov1, d8, bo8, ov8, m1_diff, m1_bout, m8_diff, m8_bout);
         end
      end
   endtask

   initial begin
      test_reset();
      test_exhaustive_w1();
      test_latency();
      test_w8_values();
      test_hold();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
